// File: rtl/eth_udp_gen_pkg.sv
// Shared types and constants for the UDP test-traffic generator.
// One-hot FSM encoding, payload modes and the PRBS8 feedback helper.
package eth_udp_gen_pkg;

    typedef enum logic [9:0] {
        S_IDLE      = 10'b00_0000_0001,
        S_ARP_REQ   = 10'b00_0000_0010,
        S_ARP_SEND  = 10'b00_0000_0100,
        S_ARP_WAIT  = 10'b00_0000_1000,
        S_GEN_REQ   = 10'b00_0001_0000,
        S_WRITE     = 10'b00_0010_0000,
        S_SEND      = 10'b00_0100_0000,
        S_WAIT      = 10'b00_1000_0000,
        S_CHECK_ARP = 10'b01_0000_0000,
        S_FAIL      = 10'b10_0000_0000
    } state_t;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_PRBS = 2'd1;
    localparam logic [1:0] MODE_FILL = 2'd2;
    localparam logic [1:0] MODE_SEQ  = 2'd3;

    // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int UDP_MAX_PAYLOAD = 1472;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/eth_udp_traffic_gen_pattern.sv
// Payload byte source: byte index, PRBS8 register and per-frame
// snapshots of mode, fill byte and the frame-count header.
module udp_pattern_gen
    import eth_udp_gen_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  logic [1:0]  mode,
    input  logic [7:0]  fill_byte,
    input  logic [31:0] frame_cnt,
    output logic [7:0]  data
);

    logic [10:0] idx;
    logic [7:0]  lfsr;
    logic [1:0]  mode_q;
    logic [7:0]  fill_q;
    logic [31:0] hdr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            lfsr   <= LFSR_SEED;
            mode_q <= MODE_INC;
            fill_q <= '0;
            hdr_q  <= '0;
        end else if (load) begin
            idx    <= '0;
            lfsr   <= LFSR_SEED;
            mode_q <= mode;
            fill_q <= fill_byte;
            hdr_q  <= frame_cnt;
        end else if (advance) begin
            idx  <= idx + 11'd1;
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_comb begin
        data = '0;
        unique case (mode_q)
            MODE_INC:  data = idx[7:0];
            MODE_PRBS: data = lfsr;
            MODE_FILL: data = fill_q;
            MODE_SEQ: begin
                // big-endian frame count in bytes 0..3
                if (idx < 11'd4) data = hdr_q[{~idx[1:0], 3'b000} +: 8];
                else             data = idx[7:0] - 8'd4;
            end
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/eth_udp_traffic_gen.sv
// UDP test-traffic controller: ARP resolution with bounded retries,
// then one clamped-length patterned frame per dwell period.
module eth_udp_traffic_gen
    import eth_udp_gen_pkg::*;
#(
    parameter int         PERIOD_CYCLES = 125_000_000,
    parameter int         MAX_LEN       = UDP_MAX_PAYLOAD,
    parameter int         ARP_RETRY_MAX = 4,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic        rgmii_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [10:0] payload_len,
    input  logic [7:0]  fill_byte,
    output logic        app_data_request,
    input  logic        udp_send_ack,
    output logic        app_data_in_valid,
    output logic [7:0]  app_data_in,
    output logic [15:0] app_data_length,
    output logic        arp_req,
    input  logic        arp_found,
    input  logic        mac_not_exist,
    input  logic        mac_send_end,
    output logic [31:0] frame_cnt,
    output logic        arp_fail,
    output logic        busy
);

    localparam int CW = $clog2(PERIOD_CYCLES + 1);
    localparam int RW = $clog2(ARP_RETRY_MAX + 1);
    localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);

    state_t      state, nxt;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry;
    logic [10:0] rem, len_q, len_clamped;
    logic        enable_q, dwell_end, last_retry;
    logic        emit, load;
    logic [7:0]  pat;

    assign dwell_end  = (cnt == CW'(PERIOD_CYCLES - 1));
    assign last_retry = (retry == RW'(ARP_RETRY_MAX - 1));
    assign emit = (state == S_GEN_REQ && udp_send_ack) ||
                  (state == S_WRITE && rem != '0);
    assign load = (state == S_CHECK_ARP) && (nxt == S_GEN_REQ);
    assign app_data_length = {5'b0, len_q};

    always_comb begin
        len_clamped = payload_len;
        if (payload_len == '0)         len_clamped = 11'd1;
        else if (payload_len > LEN_MAX) len_clamped = LEN_MAX;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:      if (enable && dwell_end) nxt = S_ARP_REQ;
            S_ARP_REQ:   nxt = S_ARP_SEND;
            S_ARP_SEND:  if (mac_send_end) nxt = S_ARP_WAIT;
            S_ARP_WAIT: begin
                if (!enable)        nxt = S_IDLE;
                else if (arp_found) nxt = S_WAIT;
                else if (dwell_end) nxt = last_retry ? S_FAIL : S_ARP_REQ;
            end
            S_GEN_REQ:   if (udp_send_ack) nxt = S_WRITE;
            S_WRITE:     if (rem == '0) nxt = S_SEND;
            S_SEND:      if (mac_send_end) nxt = S_WAIT;
            S_WAIT: begin
                if (!enable)        nxt = S_IDLE;
                else if (dwell_end) nxt = S_CHECK_ARP;
            end
            S_CHECK_ARP: nxt = mac_not_exist ? S_ARP_REQ : S_GEN_REQ;
            S_FAIL:      if (!enable) nxt = S_IDLE;
            default:     nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            retry             <= '0;
            rem               <= '0;
            len_q             <= '0;
            enable_q          <= 1'b0;
            app_data_request  <= 1'b0;
            app_data_in_valid <= 1'b0;
            app_data_in       <= '0;
            arp_req           <= 1'b0;
            frame_cnt         <= '0;
            arp_fail          <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state            <= nxt;
            enable_q         <= enable;
            app_data_request <= (nxt == S_GEN_REQ);
            arp_req          <= (nxt == S_ARP_REQ);
            busy             <= !(nxt inside {S_IDLE, S_FAIL});

            // dwell counter wraps in IDLE so a late enable still waits
            if (nxt != state || dwell_end ||
                !(state inside {S_IDLE, S_ARP_WAIT, S_WAIT}))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (nxt != state && (nxt == S_WAIT || nxt == S_IDLE))
                retry <= '0;
            else if (state == S_ARP_WAIT && (nxt == S_ARP_REQ || nxt == S_FAIL))
                retry <= retry + 1'b1;

            if (nxt == S_FAIL && state != S_FAIL) arp_fail <= 1'b1;
            else if (enable && !enable_q)         arp_fail <= 1'b0;

            if (state == S_SEND && mac_send_end) frame_cnt <= frame_cnt + 32'd1;
            if (load) len_q <= len_clamped;

            if (emit) begin
                app_data_in_valid <= 1'b1;
                app_data_in       <= pat;
                rem <= (state == S_GEN_REQ) ? len_q - 11'd1 : rem - 11'd1;
            end else begin
                app_data_in_valid <= 1'b0;
                app_data_in       <= '0;
            end
        end
    end

    udp_pattern_gen #(.LFSR_SEED(LFSR_SEED)) u_pattern (
        .clk       (rgmii_clk),
        .rst       (rst),
        .load      (load),
        .advance   (emit),
        .mode      (mode),
        .fill_byte (fill_byte),
        .frame_cnt (frame_cnt),
        .data      (pat)
    );

endmodule

// File: tb/tb_eth_udp_traffic_gen.sv
// Scoreboard bench for eth_udp_traffic_gen with a behavioural MAC/ARP
// responder; expected payload bytes are queued when a frame is configured.
module tb_eth_udp_traffic_gen;

    logic        rgmii_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [10:0] payload_len = '0;
    logic [7:0]  fill_byte = '0;
    logic        udp_send_ack = 1'b0;
    logic        arp_found = 1'b0;
    logic        mac_not_exist = 1'b0;
    logic        mac_send_end = 1'b0;
    logic        app_data_request, app_data_in_valid, arp_req, arp_fail, busy;
    logic [7:0]  app_data_in;
    logic [15:0] app_data_length;
    logic [31:0] frame_cnt;

    eth_udp_traffic_gen #(.PERIOD_CYCLES(100)) dut (
        .rgmii_clk         (rgmii_clk),
        .rst               (rst),
        .enable            (enable),
        .mode              (mode),
        .payload_len       (payload_len),
        .fill_byte         (fill_byte),
        .app_data_request  (app_data_request),
        .udp_send_ack      (udp_send_ack),
        .app_data_in_valid (app_data_in_valid),
        .app_data_in       (app_data_in),
        .app_data_length   (app_data_length),
        .arp_req           (arp_req),
        .arp_found         (arp_found),
        .mac_not_exist     (mac_not_exist),
        .mac_send_end      (mac_send_end),
        .frame_cnt         (frame_cnt),
        .arp_fail          (arp_fail),
        .busy              (busy)
    );

    always #4 rgmii_clk = ~rgmii_clk;

    int cyc = 0;
    always @(posedge rgmii_clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    int len_exp_q[$];
    int arp_t[$];
    int arp_pulses = 0;
    int t_found = -1;
    int t_req = -1;
    int run = 0;
    int nframes = 0;
    bit arp_reply = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [1:0] m, input int k,
                                            input logic [7:0] f, input logic [31:0] fc);
        logic [31:0] h;
        case (m)
            2'd0: return 8'(k);
            2'd1: case (k)
                      0: return 8'hA5;
                      1: return 8'h4A;
                      2: return 8'h95;
                      3: return 8'h2A;
                      default: return 8'h00;
                  endcase
            2'd2: return f;
            default: begin
                if (k < 4) begin
                    h = fc >> (8 * (3 - k));
                    return h[7:0];
                end
                return 8'(k - 4);
            end
        endcase
    endfunction

    task automatic start_frame(input logic [1:0] m, input logic [10:0] len,
                               input logic [7:0] f, input int l_exp);
        mode = m;
        payload_len = len;
        fill_byte = f;
        for (int k = 0; k < l_exp; k++) exp_q.push_back(exp_byte(m, k, f, 32'(nframes)));
        len_exp_q.push_back(l_exp);
    endtask

    task automatic wait_frame();
        for (int k = 0; k < 5000 && frame_cnt != 32'(nframes + 1); k++)
            @(negedge rgmii_clk);
        nframes++;
        chk("frame_cnt", frame_cnt, 32'(nframes));
        chk("sb_drained", 32'(exp_q.size()), 0);
    endtask

    // MAC / ARP side of udp_ip_mac_top
    initial begin
        forever begin
            @(negedge rgmii_clk);
            if (rst) continue;
            if (arp_req) begin
                arp_pulses++;
                arp_t.push_back(cyc);
                repeat (3) @(negedge rgmii_clk);
                mac_send_end = 1'b1;
                @(negedge rgmii_clk);
                mac_send_end = 1'b0;
                if (arp_reply) begin
                    repeat (4) @(negedge rgmii_clk);
                    arp_found = 1'b1;
                    if (t_found < 0) t_found = cyc + 1;
                    @(negedge rgmii_clk);
                    arp_found = 1'b0;
                end
            end else if (app_data_request) begin
                repeat (2) @(negedge rgmii_clk);
                udp_send_ack = 1'b1;
                @(negedge rgmii_clk);
                udp_send_ack = 1'b0;
                for (int k = 0; k < 3000 && app_data_in_valid; k++) @(negedge rgmii_clk);
                repeat (3) @(negedge rgmii_clk);
                mac_send_end = 1'b1;
                @(negedge rgmii_clk);
                mac_send_end = 1'b0;
            end
        end
    end

    // monitor: pops expected bytes and frame lengths
    initial begin
        forever begin
            @(negedge rgmii_clk);
            if (rst) continue;
            if (app_data_request && t_req < 0) t_req = cyc;
            if (app_data_in_valid) begin
                if (run == 0 && len_exp_q.size() > 0)
                    chk("app_data_length", 32'(app_data_length), 32'(len_exp_q[0]));
                run++;
                if (exp_q.size() == 0) chk("extra_byte", 32'(app_data_in), 32'hFFFF_FFFF);
                else chk("data", 32'(app_data_in), 32'(exp_q.pop_front()));
            end else begin
                chk("data_idle_zero", 32'(app_data_in), 0);
                if (run != 0) begin
                    if (len_exp_q.size() == 0) chk("unexpected_frame", 32'(run), 0);
                    else chk("valid_run", 32'(run), 32'(len_exp_q.pop_front()));
                    run = 0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge rgmii_clk);
        chk("rst_request", 32'(app_data_request), 0);
        chk("rst_valid", 32'(app_data_in_valid), 0);
        chk("rst_data", 32'(app_data_in), 0);
        chk("rst_length", 32'(app_data_length), 0);
        chk("rst_arp_req", 32'(arp_req), 0);
        chk("rst_arp_fail", 32'(arp_fail), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        start_frame(2'd0, 11'd300, 8'h00, 300);
        rst = 1'b0;
        enable = 1'b1;
        wait_frame();
        chk("arp_single_pulse", 32'(arp_pulses), 1);
        chk("req_latency", 32'(t_req - t_found), 101);

        start_frame(2'd1, 11'd4, 8'h00, 4);
        wait_frame();
        start_frame(2'd1, 11'd4, 8'h00, 4);
        wait_frame();
        start_frame(2'd3, 11'd6, 8'h00, 6);
        wait_frame();
        start_frame(2'd2, 11'd0, 8'h5A, 1);
        wait_frame();
        start_frame(2'd0, 11'd2000, 8'h00, 1472);
        wait_frame();

        start_frame(2'd2, 11'd3, 8'hC3, 3);
        for (int k = 0; k < 1000 && !app_data_in_valid; k++) @(negedge rgmii_clk);
        chk("valid_seen", 32'(app_data_in_valid), 1);
        enable = 1'b0;
        wait_frame();
        repeat (3) @(negedge rgmii_clk);
        chk("busy_after_drop", 32'(busy), 0);
        repeat (150) @(negedge rgmii_clk);
        chk("no_frame_idle", frame_cnt, 32'(nframes));
        chk("no_arp_idle", 32'(arp_pulses), 1);

        arp_reply = 1'b0;
        arp_pulses = 0;
        arp_t.delete();
        enable = 1'b1;
        for (int k = 0; k < 1500 && !arp_fail; k++) @(negedge rgmii_clk);
        chk("arp_fail_set", 32'(arp_fail), 1);
        chk("arp_pulses_fail", 32'(arp_pulses), 4);
        for (int i = 1; i < arp_t.size(); i++)
            chk("arp_spacing", 32'(arp_t[i] - arp_t[i-1] >= 100), 1);
        chk("busy_fail", 32'(busy), 0);
        enable = 1'b0;
        repeat (3) @(negedge rgmii_clk);
        chk("arp_fail_sticky", 32'(arp_fail), 1);
        chk("busy_idle", 32'(busy), 0);
        enable = 1'b1;
        repeat (2) @(negedge rgmii_clk);
        chk("arp_fail_clear", 32'(arp_fail), 0);
        enable = 1'b0;
        repeat (20) @(negedge rgmii_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
